b16_bus_arbiter: RTL and testbench

- Shares one 16-bit memory port between the b16 cpu and a second bus master (DMA or host loader).
- Stalls the cpu through its `run` input whenever the cpu does not own the bus, or its access is waiting on memory.
- Sits between the cpu memory pins (addr/rd/wr/data/dataout) and the memory/peripheral bus.
- Inserts wait states from a `mem_ready` handshake and bounds external bursts so the cpu cannot starve.

---
 rtl/b16_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_b16_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b16_bus_arbiter.sv
// b16 bus arbiter: shares one memory port between the b16 cpu and an
// external master, with wait states, burst bounding and cpu fairness.
//
// Ports:
//   clk, nreset        clock, async active-low reset
//   run_in / cpu_run   debugger run request in, gated run out to cpu
//   cpu_*              cpu memory pins (addr, rd, wr, dout, din)
//   ext_*              external master (req, addr, rd, wr, wdata,
//                      gnt, ack, rdata)
//   mem_*              shared memory bus (addr, rd, wr, wdata,
//                      rdata, ready)
module b16_bus_arbiter #(
  parameter int l        = 16,
  parameter int maxburst = 4,
  parameter int cw       = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         run_in,
  output logic         cpu_run,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_dout,
  output logic [l-1:0] cpu_din,
  input  logic         ext_req,
  input  logic [l-1:0] ext_addr,
  input  logic         ext_rd,
  input  logic [1:0]   ext_wr,
  input  logic [l-1:0] ext_wdata,
  output logic         ext_gnt,
  output logic         ext_ack,
  output logic [l-1:0] ext_rdata,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_wdata,
  input  logic [l-1:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic {
    CPU = 1'b0,
    EXT = 1'b1
  } owner_t;

  owner_t        owner;
  owner_t        owner_n;
  logic [cw-1:0] cnt;
  logic [cw-1:0] cnt_n;
  logic [cw:0]   cnt_inc;
  logic          owed;
  logic          owed_n;
  logic          cpu_acc;
  logic          ext_acc;
  logic          is_cpu;
  logic          last;
  logic          cpu_en;

  assign cpu_acc = cpu_rd | (|cpu_wr);
  assign ext_acc = ext_rd | (|ext_wr);
  assign is_cpu  = (owner == CPU);
  assign cpu_en  = nreset & run_in;

  assign cpu_run = cpu_en & is_cpu
                 & (mem_ready | ~cpu_acc);
  assign ext_gnt = nreset & ~is_cpu;
  assign ext_ack = ext_gnt & ext_acc & mem_ready;

  assign cpu_din   = mem_rdata;
  assign ext_rdata = mem_rdata;

  assign cnt_inc = {1'b0, cnt} + (cw+1)'(1);
  assign last    = (cnt_inc == (cw+1)'(maxburst));

  // Only the registered owner steers the mux, so ext_req
  // never reaches mem_* combinationally.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_dout;
    mem_rd    = cpu_rd & cpu_en;
    mem_wr    = cpu_wr & {2{cpu_en}};
    if (!is_cpu) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_rd    = ext_rd & nreset;
      mem_wr    = ext_wr & {2{nreset}};
    end
  end

  always_comb begin
    owner_n = owner;
    cnt_n   = cnt;
    owed_n  = owed;
    unique case (owner)
      CPU: begin
        if (cpu_run)
          owed_n = 1'b0;
        // Grant only on a completed step or a halted cpu;
        // a stalled cpu access is never preempted.
        if (ext_req && !owed &&
            (cpu_run || !run_in)) begin
          owner_n = EXT;
          cnt_n   = '0;
        end
      end
      EXT: begin
        if (ext_ack && cnt != cw'(maxburst))
          cnt_n = cnt_inc[cw-1:0];
        // Burst limit wins over a simultaneous ext_req drop.
        if (ext_ack && last) begin
          owner_n = CPU;
          owed_n  = 1'b1;
        end else if (!ext_req && !ext_acc) begin
          owner_n = CPU;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      owner <= CPU;
      cnt   <= '0;
      owed  <= 1'b0;
    end else begin
      owner <= owner_n;
      cnt   <= cnt_n;
      owed  <= owed_n;
    end
  end

endmodule

// File: tb/tb_b16_bus_arbiter.sv
// Directed self-checking bench for b16_bus_arbiter.
// Inputs change 1ns after a rising edge; checks run 2ns later.
module tb_b16_bus_arbiter;

  logic        clk;
  logic        nreset;
  logic        run_in;
  logic        cpu_run;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic [1:0]  cpu_wr;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        ext_req;
  logic [15:0] ext_addr;
  logic        ext_rd;
  logic [1:0]  ext_wr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_ack;
  logic [15:0] ext_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [1:0]  mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int total;
  int passed;
  int fails;

  b16_bus_arbiter #(
    .l(16),
    .maxburst(4),
    .cw(4)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .run_in(run_in),
    .cpu_run(cpu_run),
    .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout),
    .cpu_din(cpu_din),
    .ext_req(ext_req),
    .ext_addr(ext_addr),
    .ext_rd(ext_rd),
    .ext_wr(ext_wr),
    .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt),
    .ext_ack(ext_ack),
    .ext_rdata(ext_rdata),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    fails = 0;
    nreset = 1'b0;
    run_in = 1'b1;
    cpu_addr = 16'h0000;
    cpu_rd = 1'b1;
    cpu_wr = 2'b11;
    cpu_dout = 16'h5A5A;
    ext_req = 1'b1;
    ext_addr = 16'h0000;
    ext_rd = 1'b1;
    ext_wr = 2'b00;
    ext_wdata = 16'h0000;
    mem_rdata = 16'h0000;
    mem_ready = 1'b1;
    #2;
    chk("rst_run", 16'(cpu_run), 16'h0);
    chk("rst_gnt", 16'(ext_gnt), 16'h0);
    chk("rst_ack", 16'(ext_ack), 16'h0);
    chk("rst_rd", 16'(mem_rd), 16'h0);
    chk("rst_wr", 16'(mem_wr), 16'h0);
    tick();
    tick();

    // cpu reads across 0x3FFE / 0x4000, no ext traffic
    nreset = 1'b1;
    ext_req = 1'b0;
    ext_rd = 1'b0;
    cpu_wr = 2'b00;
    cpu_addr = 16'h3FFE;
    mem_rdata = 16'h1234;
    #2;
    chk("b1_run", 16'(cpu_run), 16'h1);
    chk("b1_addr", mem_addr, 16'h3FFE);
    chk("b1_rd", 16'(mem_rd), 16'h1);
    chk("b1_din", cpu_din, 16'h1234);
    chk("b1_gnt", 16'(ext_gnt), 16'h0);
    tick();
    cpu_addr = 16'h4000;
    #2;
    chk("b2_run", 16'(cpu_run), 16'h1);
    chk("b2_addr", mem_addr, 16'h4000);
    chk("b2_gnt", 16'(ext_gnt), 16'h0);

    // stalled cpu read is not preempted by ext_req
    tick();
    mem_ready = 1'b0;
    ext_req = 1'b1;
    #2;
    chk("c1_run", 16'(cpu_run), 16'h0);
    chk("c1_gnt", 16'(ext_gnt), 16'h0);
    tick();
    #2;
    chk("c2_run", 16'(cpu_run), 16'h0);
    chk("c2_gnt", 16'(ext_gnt), 16'h0);
    tick();
    #2;
    chk("c3_run", 16'(cpu_run), 16'h0);
    chk("c3_gnt", 16'(ext_gnt), 16'h0);
    chk("c3_rd", 16'(mem_rd), 16'h1);
    tick();
    mem_ready = 1'b1;
    #2;
    chk("c4_run", 16'(cpu_run), 16'h1);
    chk("c4_gnt", 16'(ext_gnt), 16'h0);

    // 4-access ext write burst, then burst-limit exit
    tick();
    cpu_rd = 1'b0;
    ext_wr = 2'b11;
    ext_addr = 16'h1000;
    ext_wdata = 16'hA000;
    #2;
    chk("d0_gnt", 16'(ext_gnt), 16'h1);
    chk("d0_run", 16'(cpu_run), 16'h0);
    chk("d0_ack", 16'(ext_ack), 16'h1);
    chk("d0_addr", mem_addr, 16'h1000);
    chk("d0_wr", 16'(mem_wr), 16'h3);
    chk("d0_wd", mem_wdata, 16'hA000);
    for (int i = 1; i < 4; i++) begin
      tick();
      ext_addr = 16'h1000 + 16'(2 * i);
      #2;
      chk("d_ack", 16'(ext_ack), 16'h1);
      chk("d_addr", mem_addr, 16'h1000 + 16'(2 * i));
    end
    tick();
    ext_addr = 16'h1008;
    #2;
    chk("d5_gnt", 16'(ext_gnt), 16'h0);
    chk("d5_ack", 16'(ext_ack), 16'h0);
    chk("d5_run", 16'(cpu_run), 16'h1);
    chk("d5_wr", 16'(mem_wr), 16'h0);
    tick();
    #2;
    chk("d6_gnt", 16'(ext_gnt), 16'h0);
    chk("d6_run", 16'(cpu_run), 16'h1);

    // stalled ext read holds grant after ext_req drops
    tick();
    ext_wr = 2'b00;
    ext_rd = 1'b1;
    ext_addr = 16'h2000;
    ext_req = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("e1_gnt", 16'(ext_gnt), 16'h1);
    chk("e1_ack", 16'(ext_ack), 16'h0);
    chk("e1_rd", 16'(mem_rd), 16'h1);
    chk("e1_addr", mem_addr, 16'h2000);
    tick();
    #2;
    chk("e2_gnt", 16'(ext_gnt), 16'h1);
    chk("e2_ack", 16'(ext_ack), 16'h0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    #2;
    chk("e3_ack", 16'(ext_ack), 16'h1);
    chk("e3_rdata", ext_rdata, 16'hBEEF);
    tick();
    ext_rd = 1'b0;
    #2;
    chk("e4_gnt", 16'(ext_gnt), 16'h1);
    chk("e4_ack", 16'(ext_ack), 16'h0);
    tick();
    ext_req = 1'b1;
    #2;
    chk("e5_gnt", 16'(ext_gnt), 16'h0);
    chk("e5_run", 16'(cpu_run), 16'h1);
    tick();
    #2;
    chk("e6_gnt", 16'(ext_gnt), 16'h1);
    ext_req = 1'b0;

    // halted cpu: grant, burst limit, held off until a step
    tick();
    run_in = 1'b0;
    ext_req = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = 16'h5555;
    #2;
    chk("f1_gnt", 16'(ext_gnt), 16'h0);
    chk("f1_run", 16'(cpu_run), 16'h0);
    chk("f1_rd", 16'(mem_rd), 16'h0);
    tick();
    ext_wr = 2'b01;
    ext_addr = 16'h3000;
    #2;
    chk("f2_gnt", 16'(ext_gnt), 16'h1);
    chk("f2_run", 16'(cpu_run), 16'h0);
    chk("f2_rd", 16'(mem_rd), 16'h0);
    chk("f2_ack", 16'(ext_ack), 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("f_ack", 16'(ext_ack), 16'h1);
    end
    tick();
    #2;
    chk("f3_gnt", 16'(ext_gnt), 16'h0);
    chk("f3_run", 16'(cpu_run), 16'h0);
    chk("f3_wr", 16'(mem_wr), 16'h0);
    tick();
    #2;
    chk("f4_gnt", 16'(ext_gnt), 16'h0);
    tick();
    run_in = 1'b1;
    #2;
    chk("f5_run", 16'(cpu_run), 16'h1);
    chk("f5_gnt", 16'(ext_gnt), 16'h0);
    chk("f5_addr", mem_addr, 16'h5555);
    tick();
    #2;
    chk("f6_gnt", 16'(ext_gnt), 16'h0);
    chk("f6_run", 16'(cpu_run), 16'h1);
    tick();
    #2;
    chk("f7_gnt", 16'(ext_gnt), 16'h1);
    chk("f7_ack", 16'(ext_ack), 16'h1);

    // async reset mid-burst with cnt=2
    tick();
    #2;
    chk("g1_ack", 16'(ext_ack), 16'h1);
    tick();
    nreset = 1'b0;
    #2;
    chk("g2_gnt", 16'(ext_gnt), 16'h0);
    chk("g2_wr", 16'(mem_wr), 16'h0);
    chk("g2_run", 16'(cpu_run), 16'h0);
    chk("g2_ack", 16'(ext_ack), 16'h0);
    tick();
    tick();
    nreset = 1'b1;
    cpu_rd = 1'b0;
    #2;
    chk("g3_gnt", 16'(ext_gnt), 16'h0);
    chk("g3_run", 16'(cpu_run), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      chk("g_gnt", 16'(ext_gnt), 16'h1);
      chk("g_ack", 16'(ext_ack), 16'h1);
    end
    tick();
    #2;
    chk("g4_gnt", 16'(ext_gnt), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
